// File: rtl/bx_merge_sched_pkg.sv
// Shared types and helpers for the per-BX merge scheduler.
// Holds the FSM state encoding, the read-source tag and a clamp helper.
// Latency: n/a (types only). Backpressure: n/a.
package bx_merge_pkg;

  // Capacity of one memout page at the default address width.
  localparam int unsigned DEPTH = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  typedef enum logic {
    SRC_MEM1 = 1'b0,
    SRC_MEM2 = 1'b1
  } src_t;

  // Upper clamp: entry counts above the page capacity are capped at it.
  function automatic logic [31:0] clamp_max(input logic [31:0] val, input logic [31:0] lim);
    return (val > lim) ? lim : val;
  endfunction

endpackage

// File: rtl/bx_merge_sched_if.sv
// Memory-side bus of the merge scheduler: two paged input BRAM read ports
// and one paged output BRAM write port. master = scheduler, slave = memories.
// Latency: n/a (wiring only). Backpressure: none, BRAM ports never stall.
interface bx_merge_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4,
  parameter int NENT_W = 5,
  parameter int PAGE_W = 1
);
  logic [NENT_W-1:0] mem1_nent;
  logic              mem1_enb;
  logic [ADDR_W-1:0] mem1_readaddr;
  logic [DATA_W-1:0] mem1_dout;

  logic [NENT_W-1:0] mem2_nent;
  logic              mem2_enb;
  logic [ADDR_W-1:0] mem2_readaddr;
  logic [DATA_W-1:0] mem2_dout;

  logic              memout_wea;
  logic [ADDR_W-1:0] memout_writeaddr;
  logic [DATA_W-1:0] memout_din;
  logic [PAGE_W-1:0] memout_pagea;
  logic [NENT_W-1:0] memout_nent;

  modport master (
    input  mem1_nent, mem1_dout, mem2_nent, mem2_dout,
    output mem1_enb, mem1_readaddr, mem2_enb, mem2_readaddr,
    output memout_wea, memout_writeaddr, memout_din, memout_pagea, memout_nent
  );

  modport slave (
    output mem1_nent, mem1_dout, mem2_nent, mem2_dout,
    input  mem1_enb, mem1_readaddr, mem2_enb, mem2_readaddr,
    input  memout_wea, memout_writeaddr, memout_din, memout_pagea, memout_nent
  );
endinterface

// File: rtl/bx_merge_sched_rd_lat_pipe.sv
// Read-latency tracker: LAT-deep shift register of {valid, src} tags that
// lines each issued read up with the cycle its BRAM data appears.
// Latency: LAT cycles. Backpressure: none; flush clears every stage synchronously.
// Ports: clk/reset, flush, in_vld/in_src (issue side), out_vld/out_src (tail), busy (any stage valid).
module rd_lat_pipe
  import bx_merge_pkg::*;
#(
  parameter int LAT = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic flush,
  input  logic in_vld,
  input  src_t in_src,
  output logic out_vld,
  output src_t out_src,
  output logic busy
);

  logic [LAT-1:0] vld_q;
  src_t           src_q [LAT];

  always_ff @(posedge clk) begin
    if (!reset || flush) begin
      vld_q <= '0;
      for (int i = 0; i < LAT; i++) src_q[i] <= SRC_MEM1;
    end else begin
      vld_q[0] <= in_vld;
      src_q[0] <= in_src;
      for (int i = 1; i < LAT; i++) begin
        vld_q[i] <= vld_q[i-1];
        src_q[i] <= src_q[i-1];
      end
    end
  end

  assign out_vld = vld_q[LAT-1];
  assign out_src = src_q[LAT-1];
  assign busy    = |vld_q;

endmodule

// File: rtl/bx_merge_sched.sv
// Per-BX read scheduler: on each new BX reads the valid entries of mem1/mem2
// (round-robin, mem1 first), and writes the merged stream to the memout page
// selected by the BX, reporting count, overflow, truncation and completion.
// Latency: first write RD_LAT+1 cycles after bx_in changes; done at N+RD_LAT+2
// (2 cycles for an empty BX). Backpressure: none; a new BX aborts the current one.
// Ports: clk, reset (sync, active low), en_proc, bx_in, bx_out, done, trunc, ovf,
//        mem (master side of bx_merge_if: mem1/mem2 read ports, memout write port).
module bx_merge_sched
  import bx_merge_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4,
  parameter int NENT_W = 5,
  parameter int BX_W   = 2,
  parameter int PAGE_W = 1,
  parameter int RD_LAT = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            en_proc,
  input  logic [BX_W-1:0] bx_in,
  output logic [BX_W-1:0] bx_out,
  output logic            done,
  output logic            trunc,
  output logic            ovf,
  bx_merge_if.master      mem
);

  localparam int unsigned CAP = 1 << ADDR_W;

  state_t            state_q, state_d;
  logic [BX_W-1:0]   bx_prev_q, bx_cur_q, bx_out_q;
  logic [NENT_W-1:0] n1_q, n2_q, rd1_q, rd2_q, wr_q;
  logic              pref2_q;
  logic              ovf_q;
  logic [PAGE_W-1:0] page_q;

  logic              new_bx;
  logic              elig1, elig2, issue_en, pick2, iss1, iss2;
  src_t              issue_src, tail_src;
  logic              tail_vld, pipe_busy;
  logic              wr_en, full, wea;
  logic [DATA_W-1:0] tail_dout;

  assign new_bx = en_proc && (bx_in != bx_prev_q);

  // Read issue. Nothing is issued in a new-BX cycle: the counters still
  // belong to the BX being replaced.
  assign elig1     = rd1_q < n1_q;
  assign elig2     = rd2_q < n2_q;
  assign issue_en  = (state_q == RUN) && !new_bx && (elig1 || elig2);
  assign pick2     = elig2 && (!elig1 || pref2_q);
  assign iss1      = issue_en && !pick2;
  assign iss2      = issue_en && pick2;
  assign issue_src = pick2 ? SRC_MEM2 : SRC_MEM1;

  rd_lat_pipe #(
    .LAT(RD_LAT)
  ) u_rd_lat_pipe (
    .clk     (clk),
    .reset   (reset),
    .flush   (new_bx),
    .in_vld  (iss1 || iss2),
    .in_src  (issue_src),
    .out_vld (tail_vld),
    .out_src (tail_src),
    .busy    (pipe_busy)
  );

  // Write side. Data arriving in a new-BX cycle belongs to the aborted BX.
  assign tail_dout = (tail_src == SRC_MEM2) ? mem.mem2_dout : mem.mem1_dout;
  assign wr_en     = tail_vld && !new_bx;
  assign full      = (wr_q == NENT_W'(CAP));
  assign wea       = wr_en && !full;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (new_bx) state_d = RUN;
      RUN: begin
        if (new_bx)                         state_d = RUN;
        else if (n1_q == '0 && n2_q == '0)  state_d = DONE;
        else if (!(elig1 || elig2))         state_d = DRAIN;
      end
      DRAIN: begin
        if (new_bx)          state_d = RUN;
        else if (!pipe_busy) state_d = DONE;
      end
      DONE:  state_d = new_bx ? RUN : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= IDLE;
      bx_prev_q <= bx_in;  // suppress a spurious detect right after reset
      bx_cur_q  <= '0;
      bx_out_q  <= '0;
      n1_q      <= '0;
      n2_q      <= '0;
      rd1_q     <= '0;
      rd2_q     <= '0;
      wr_q      <= '0;
      pref2_q   <= 1'b0;
      ovf_q     <= 1'b0;
      page_q    <= '0;
    end else begin
      state_q   <= state_d;
      bx_prev_q <= bx_in;  // tracks even with en_proc low
      if (state_q == DONE) bx_out_q <= bx_cur_q;
      if (new_bx) begin
        bx_cur_q <= bx_in;
        n1_q     <= NENT_W'(clamp_max(32'(mem.mem1_nent), CAP));
        n2_q     <= NENT_W'(clamp_max(32'(mem.mem2_nent), CAP));
        rd1_q    <= '0;
        rd2_q    <= '0;
        wr_q     <= '0;
        pref2_q  <= 1'b0;
        ovf_q    <= 1'b0;
        page_q   <= bx_in[PAGE_W-1:0];
      end else begin
        if (iss1) begin
          rd1_q   <= rd1_q + 1'b1;
          pref2_q <= 1'b1;
        end
        if (iss2) begin
          rd2_q   <= rd2_q + 1'b1;
          pref2_q <= 1'b0;
        end
        if (wea)          wr_q  <= wr_q + 1'b1;
        if (wr_en && full) ovf_q <= 1'b1;
      end
    end
  end

  assign mem.mem1_enb         = iss1;
  assign mem.mem1_readaddr    = iss1 ? rd1_q[ADDR_W-1:0] : '0;
  assign mem.mem2_enb         = iss2;
  assign mem.mem2_readaddr    = iss2 ? rd2_q[ADDR_W-1:0] : '0;
  assign mem.memout_wea       = wea;
  assign mem.memout_writeaddr = wea ? wr_q[ADDR_W-1:0] : '0;
  assign mem.memout_din       = wr_en ? tail_dout : '0;
  assign mem.memout_pagea     = page_q;
  assign mem.memout_nent      = wea ? (wr_q + 1'b1) : wr_q;

  assign ovf    = ovf_q || (wr_en && full);
  assign done   = (state_q == DONE);
  assign trunc  = new_bx && (state_q == RUN || state_q == DRAIN);
  assign bx_out = (state_q == DONE) ? bx_cur_q : bx_out_q;

endmodule

// File: tb/tb_bx_merge_sched.sv
// Bench for bx_merge_sched: behavioural BRAMs with RD_LAT read latency, a
// queue-based reference of the merged order, and cycle-exact timing expectations.
// Stimulus: directed cases followed by randomized BX sequences.
module tb_bx_merge_sched;
  import bx_merge_pkg::*;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 4;
  localparam int NENT_W = 5;
  localparam int BX_W   = 2;
  localparam int PAGE_W = 1;
  localparam int RD_LAT = 2;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic            en_proc = 1'b0;
  logic [BX_W-1:0] bx_in = '0;
  logic [BX_W-1:0] bx_out;
  logic            done, trunc, ovf;

  bx_merge_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NENT_W(NENT_W), .PAGE_W(PAGE_W)) bus ();

  bx_merge_sched #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .NENT_W(NENT_W),
    .BX_W(BX_W), .PAGE_W(PAGE_W), .RD_LAT(RD_LAT)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .en_proc (en_proc),
    .bx_in   (bx_in),
    .bx_out  (bx_out),
    .done    (done),
    .trunc   (trunc),
    .ovf     (ovf),
    .mem     (bus)
  );

  always #5 clk = ~clk;

  // Input memory contents per source / BX page / address, and raw nent per BX.
  logic [DATA_W-1:0] dat [2][4][16];
  int                n1_tab [4];
  int                n2_tab [4];
  int                rd_bx = 0;

  assign bus.mem1_nent = NENT_W'(n1_tab[bx_in]);
  assign bus.mem2_nent = NENT_W'(n2_tab[bx_in]);

  // Two-stage BRAM read path (address register + output register).
  logic [DATA_W-1:0] r1a = '0, r1b = '0, r2a = '0, r2b = '0;
  always @(posedge clk) begin
    if (bus.mem1_enb) r1a <= dat[0][rd_bx][bus.mem1_readaddr];
    if (bus.mem2_enb) r2a <= dat[1][rd_bx][bus.mem2_readaddr];
    r1b <= r1a;
    r2b <= r2a;
  end
  assign bus.mem1_dout = r1b;
  assign bus.mem2_dout = r2b;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
  endtask

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  typedef struct {
    int src;
    int addr;
  } rd_t;
  rd_t exp_q[$];

  // Merged order: pair m1[k], m2[k] for each k, skipping exhausted sources.
  task automatic build_order(input int a_raw, input int b_raw);
    int a, b;
    rd_t e;
    a = imin(a_raw, DEPTH);
    b = imin(b_raw, DEPTH);
    exp_q.delete();
    for (int k = 0; k < ((a > b) ? a : b); k++) begin
      if (k < a) begin e.src = 0; e.addr = k; exp_q.push_back(e); end
      if (k < b) begin e.src = 1; e.addr = k; exp_q.push_back(e); end
    end
  endtask

  task automatic start_bx(input int bx, input int a, input int b);
    for (int i = 0; i < 16; i++) begin
      dat[0][bx][i] = $urandom;
      dat[1][bx][i] = $urandom;
    end
    n1_tab[bx] = a;
    n2_tab[bx] = b;
    rd_bx      = bx;
    bx_in      = BX_W'(bx);
  endtask

  // Called just after the edge at which bx_in took the new value.
  task automatic observe(input int bx, input int trunc_at, input int ign_at, input bit trunc0);
    int  n, ncap, done_c, nrd, nwr, t;
    bit  seen_done, cut;
    rd_t e;
    build_order(n1_tab[bx], n2_tab[bx]);
    n      = exp_q.size();
    ncap   = imin(n, DEPTH);
    done_c = (n == 0) ? 2 : n + RD_LAT + 2;
    nrd = 0; nwr = 0; t = 0; seen_done = 0; cut = 0;
    for (int c = 0; c <= done_c + 4; c++) begin
      @(negedge clk);
      check_eq("trunc", trunc, (c == 0) && trunc0);
      check_eq("done", done, c == done_c);
      if (bus.mem1_enb || bus.mem2_enb) begin
        check_eq("rd_one_src", bus.mem1_enb && bus.mem2_enb, 0);
        if (nrd < n) begin
          e = exp_q[nrd];
          check_eq("rd_src", bus.mem2_enb, e.src);
          check_eq("rd_addr", bus.mem2_enb ? bus.mem2_readaddr : bus.mem1_readaddr, e.addr);
          check_eq("rd_cycle", c, nrd + 1);
        end else check_eq("rd_extra", nrd, n);
        nrd++;
      end
      if (bus.memout_wea) begin
        if (nwr < ncap) begin
          e = exp_q[nwr];
          check_eq("wr_addr", bus.memout_writeaddr, nwr);
          check_eq("wr_din", bus.memout_din, dat[e.src][bx][e.addr]);
          check_eq("wr_page", bus.memout_pagea, bx % 2);
          check_eq("wr_cycle", c, nwr + RD_LAT + 1);
          check_eq("wr_nent", bus.memout_nent, nwr + 1);
        end else check_eq("wr_extra", nwr, ncap);
        nwr++;
      end
      if (done) begin
        seen_done = 1;
        check_eq("bx_out", bx_out, bx);
        check_eq("final_nent", bus.memout_nent, ncap);
        check_eq("final_ovf", ovf, n > DEPTH);
        break;
      end
      @(posedge clk); #1;
      if (c + 1 == trunc_at) begin cut = 1; t = c + 1; break; end
      if (c + 1 == ign_at) begin en_proc = 1'b0; bx_in = bx_in + 1'b1; end
    end
    if (cut) begin
      check_eq("rd_count_cut", nrd, imin(n, t - 1));
      check_eq("wr_count_cut", nwr, (t - RD_LAT - 1 > 0) ? imin(ncap, t - RD_LAT - 1) : 0);
    end else begin
      check_eq("done_seen", seen_done, 1);
      check_eq("rd_count", nrd, n);
      check_eq("wr_count", nwr, ncap);
    end
  endtask

  task automatic go(input int bx, input int a, input int b, input int trunc_at, input int ign_at);
    @(posedge clk); #1;
    start_bx(bx, a, b);
    observe(bx, trunc_at, ign_at, 1'b0);
  endtask

  // New BX driven in the same cycle an earlier BX was cut off.
  task automatic follow(input int bx, input int a, input int b);
    start_bx(bx, a, b);
    observe(bx, 0, 0, 1'b1);
  endtask

  task automatic check_zero(input string tag);
    check_eq({tag, "_bx_out"}, bx_out, 0);
    check_eq({tag, "_done"}, done, 0);
    check_eq({tag, "_trunc"}, trunc, 0);
    check_eq({tag, "_ovf"}, ovf, 0);
    check_eq({tag, "_enb1"}, bus.mem1_enb, 0);
    check_eq({tag, "_addr1"}, bus.mem1_readaddr, 0);
    check_eq({tag, "_enb2"}, bus.mem2_enb, 0);
    check_eq({tag, "_addr2"}, bus.mem2_readaddr, 0);
    check_eq({tag, "_wea"}, bus.memout_wea, 0);
    check_eq({tag, "_waddr"}, bus.memout_writeaddr, 0);
    check_eq({tag, "_din"}, bus.memout_din, 0);
    check_eq({tag, "_page"}, bus.memout_pagea, 0);
    check_eq({tag, "_nent"}, bus.memout_nent, 0);
  endtask

  task automatic check_quiet(input int ncyc);
    for (int i = 0; i < ncyc; i++) begin
      @(negedge clk);
      check_eq("quiet", {bus.mem1_enb, bus.mem2_enb, bus.memout_wea, done, trunc}, 0);
      @(posedge clk); #1;
    end
  endtask

  initial begin
    int nb, nb2, a, b, n, dc, t;
    for (int i = 0; i < 4; i++) begin n1_tab[i] = 0; n2_tab[i] = 0; end
    for (int s = 0; s < 2; s++)
      for (int p = 0; p < 4; p++)
        for (int i = 0; i < 16; i++) dat[s][p][i] = '0;

    // Reset state.
    reset = 1'b0; en_proc = 1'b1; bx_in = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_zero("rst");
    @(posedge clk); #1 reset = 1'b1;
    check_quiet(3);

    // Directed cases.
    go(1, 16, 0, 0, 0);        // single source, full page
    go(2, 3, 2, 0, 0);         // alternation
    go(3, 16, 16, 0, 0);       // overflow
    go(0, 0, 0, 0, 0);         // empty BX
    go(1, 16, 0, 9, 0);        // cut 8 cycles into RUN
    follow(2, 5, 7);
    go(3, 4, 6, 0, 5);         // bx change with en_proc low is ignored
    @(posedge clk); #1 en_proc = 1'b1;
    check_quiet(4);

    // Reset mid-RUN.
    @(posedge clk); #1;
    start_bx(1, 16, 0);
    repeat (6) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk); #1 reset = 1'b1;
    @(negedge clk);
    check_zero("rst_mid");
    @(posedge clk); #1;
    check_quiet(5);

    // Randomized BX sequences, some cut short.
    for (int it = 0; it < 24; it++) begin
      nb = (int'(bx_in) + 1 + int'($urandom_range(0, 2))) % 4;
      a  = int'($urandom_range(0, 20));
      b  = int'($urandom_range(0, 20));
      if ($urandom_range(0, 3) == 0) begin
        n  = imin(a, DEPTH) + imin(b, DEPTH);
        dc = (n == 0) ? 2 : n + RD_LAT + 2;
        t  = int'($urandom_range(1, dc - 1));
        go(nb, a, b, t, 0);
        nb2 = (nb + 1 + int'($urandom_range(0, 2))) % 4;
        follow(nb2, int'($urandom_range(0, 18)), int'($urandom_range(0, 18)));
      end else begin
        go(nb, a, b, 0, 0);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/bx_merge_sched.md
Name: bx_merge_sched

Overview:
- Per-bunch-crossing (BX) read scheduler for two paged input BRAMs (mem1, mem2) feeding one paged output BRAM (memout).
- On each new BX it reads the entries valid for that BX from both inputs, arbitrating round-robin between them, and compensates for the BRAM read latency.
- It writes the merged stream into the memout page selected by the BX, and reports the entry count and completion.
- It replaces the ad-hoc read sequencing inside the top-level processing block.

Parameters:
- DATA_W, 32, data width of all memories.
- ADDR_W, 4, address width; depth is 2**ADDR_W = 16.
- NENT_W, 5, width of entry counts (0..16).
- BX_W, 2, width of the BX counter.
- PAGE_W, 1, memout page select width; the page is bx[PAGE_W-1:0].
- RD_LAT, 2, input BRAM read latency in cycles (HIGH_PERFORMANCE, regceb tied high).

Ports:
- clk  in  1  system clock, 200 MHz.
- reset  in  1  synchronous, active-low reset (0 = reset).
- en_proc  in  1  processing enable; when 0 no new BX is accepted.
- bx_in  in  BX_W  current BX from the BX driver.
- bx_out  out  BX_W  BX of the last completed merge.
- done  out  1  one-cycle pulse when a BX merge completes.
- trunc  out  1  one-cycle pulse when a merge is aborted by a new BX.
- ovf  out  1  sticky per BX: more than 16 entries offered to memout.
- mem1_nent  in  NENT_W  entry count for the page addressed by bx_in.
- mem1_enb  out  1  mem1 read enable.
- mem1_readaddr  out  ADDR_W  mem1 read address.
- mem1_dout  in  DATA_W  mem1 read data.
- mem2_nent, mem2_enb, mem2_readaddr, mem2_dout  as for mem1.
- memout_wea  out  1  memout write enable.
- memout_writeaddr  out  ADDR_W  memout write address.
- memout_din  out  DATA_W  memout write data.
- memout_pagea  out  PAGE_W  memout write page.
- memout_nent  out  NENT_W  entries written so far in the current BX.

Behaviour:
- Reset (reset==0 at posedge clk): FSM goes to IDLE.
  - All outputs are 0: bx_out=0, done=0, trunc=0, ovf=0, enb=0, addresses=0, wea=0, din=0, pagea=0, nent=0.
  - Read-valid pipeline is cleared.
  - bx_prev is loaded with bx_in, so no BX is detected on the first cycle after reset.
- New-BX detect: registered bx_prev; new_bx = en_proc && (bx_in != bx_prev).
- On new_bx:
  - Latch bx_cur=bx_in.
  - Latch n1 = min(mem1_nent, 16) and n2 = min(mem2_nent, 16).
  - Clear rd1/rd2/wr counters and ovf; set memout_pagea = bx_in[PAGE_W-1:0].
  - Enter RUN the next cycle.
- FSM states: IDLE -> RUN -> DRAIN -> DONE -> IDLE.
- RUN issues at most one read per cycle:
  - Eligible sources are those with rdX < nX.
  - If both are eligible, alternate, starting with mem1 at the start of each BX.
  - If one is eligible, issue from it every cycle.
  - Issue = enbX=1, readaddrX=rdX, rdX++. The non-selected enb is 0.
  - A (valid, src) tag enters an RD_LAT-deep shift pipeline.
  - If n1==n2==0 on entry, go straight to DONE (no writes).
  - When no source is eligible, go to DRAIN.
- Write side, every cycle the pipeline tail is valid:
  - memout_din = dout of the tagged source.
  - If wr<16: wea=1, writeaddr=wr, wr++, memout_nent=wr+1.
  - If wr==16: wea=0, ovf=1 (sticky until the next BX). The data is dropped.
- DRAIN waits until the pipeline is empty, then goes to DONE.
- DONE (1 cycle): done=1, bx_out=bx_cur, then IDLE. memout_nent holds its value until the next BX.
- Latency: first write occurs RD_LAT+1 cycles after the new-BX edge. A BX with n1+n2=N<=16 completes with done at N+RD_LAT+2 cycles.
- New BX while in RUN or DRAIN:
  - Pulse trunc.
  - Flush the pipeline; in-flight data is not written.
  - Restart immediately with the new BX (same-cycle reload). done is not pulsed for the aborted BX.
- New BX in the DONE cycle: done still pulses, and the new BX is accepted the same cycle.
- en_proc=0 during RUN: current BX finishes normally, but no new BX is accepted. bx_prev still tracks bx_in, so a change during en_proc=0 is ignored.
- Reset mid-operation: immediate return to reset state; memout contents are untouched.
- Width rules:
  - Counters are NENT_W bits; addresses are counter[ADDR_W-1:0].
  - BX comparison is exact and wraps modulo 2**BX_W.

Decomposition:
- Package bx_merge_pkg:
  - FSM state enum (IDLE, RUN, DRAIN, DONE).
  - src_t enum (SRC_MEM1, SRC_MEM2).
  - Depth constant and a min-clamp function.
- Sub-module rd_lat_pipe: parameterised RD_LAT-deep shift register of {valid, src} with synchronous flush.

Test Plan:
- n1=16, n2=0, bx 0->1: mem1 addresses 0..15 on consecutive cycles; writes 0..15 to page 1; memout_nent=16; done at cycle 20; ovf=0.
- n1=3, n2=2: read order m1[0], m2[0], m1[1], m2[1], m1[2]; memout gets the same order at addresses 0..4; memout_nent=5.
- n1=n2=16: 16 writes, then ovf=1; memout_nent stays 16, no wea after address 15, done still pulses.
- n1=n2=0: no enb, no wea, done exactly 2 cycles after the BX edge.
- n1=16, bx changes 8 cycles into RUN: trunc pulse, no done, counters restart; new page is written from address 0.
- Reset pulled low mid-RUN for 1 cycle: all outputs 0 next cycle; no spurious BX detect after release until bx_in changes.
